// File: rtl/cache_pkg.sv
// Shared cache-side types and constants.
// Used by the dfp-to-bmem cacheline adapter.
package cache_pkg;

   localparam int LINE_OFFSET_BITS = 5;
   localparam int BURST_LEN        = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DATA = 3'd2,
      WR      = 3'd3,
      DONE    = 3'd4
   } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Cacheline adapter: 256-bit dfp line transfers to
// 4-beat 64-bit bmem bursts, one transaction at a time.
module cacheline_adapter #(
   parameter int BEAT_W    = 64,
   parameter int BURST_LEN = cache_pkg::BURST_LEN,
   parameter int LINE_W    = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       dfp_addr,
   input  logic              dfp_read,
   input  logic              dfp_write,
   input  logic [LINE_W-1:0] dfp_wdata,
   output logic [LINE_W-1:0] dfp_rdata,
   output logic              dfp_resp,
   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [31:0]       bmem_raddr,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);

   import cache_pkg::*;

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   if (LINE_W != BEAT_W * BURST_LEN) begin : g_bad_cfg
      $error("cacheline_adapter: LINE_W must equal BEAT_W*BURST_LEN");
   end

   adapter_state_t    state;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr;
   logic [LINE_W-1:0] rline;
   logic [LINE_W-1:0] wline;
   logic              last;
   logic              unused_ok;

   assign last      = (cnt == CNT_W'(BURST_LEN - 1));
   assign unused_ok = ^{dfp_addr[LINE_OFFSET_BITS-1:0], bmem_raddr};

   // Transaction FSM, beat counter and line buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         addr  <= '0;
         rline <= '0;
         wline <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (dfp_write) begin
                  addr  <= {dfp_addr[31:LINE_OFFSET_BITS],
                            {LINE_OFFSET_BITS{1'b0}}};
                  wline <= dfp_wdata;
                  state <= WR;
               end else if (dfp_read) begin
                  addr  <= {dfp_addr[31:LINE_OFFSET_BITS],
                            {LINE_OFFSET_BITS{1'b0}}};
                  state <= RD_REQ;
               end
            end
            RD_REQ: begin
               if (bmem_ready) begin
                  cnt   <= '0;
                  state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (bmem_rvalid) begin
                  rline[BEAT_W*cnt +: BEAT_W] <= bmem_rdata;
                  cnt <= last ? '0 : cnt + CNT_W'(1);
                  if (last) state <= DONE;
               end
            end
            WR: begin
               if (bmem_ready) begin
                  cnt <= last ? '0 : cnt + CNT_W'(1);
                  if (last) state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign dfp_resp   = (state == DONE);
   assign dfp_rdata  = rline;
   assign bmem_read  = (state == RD_REQ);
   assign bmem_write = (state == WR);
   assign bmem_addr  = (state == RD_REQ || state == RD_DATA ||
                        state == WR) ? addr : '0;
   assign bmem_wdata = (state == WR) ?
                       wline[BEAT_W*cnt +: BEAT_W] : '0;

   a_both_req: assert property (@(posedge clk) disable iff (rst)
      !(state == IDLE && dfp_read && dfp_write))
      else $warning("cacheline_adapter: read+write together, write wins");

   a_rvalid_req: assert property (@(posedge clk) disable iff (rst)
      !(state == RD_REQ && bmem_rvalid))
      else $error("cacheline_adapter: rvalid before read accepted");

   a_raddr: assert property (@(posedge clk) disable iff (rst)
      (state == RD_DATA && bmem_rvalid) |-> (bmem_raddr == addr))
      else $error("cacheline_adapter: read beat address tag mismatch");

endmodule
